sync_fifo_param: RTL and testbench
==================================

# sync_fifo_param

Parametrised single-clock FIFO. It is the next-generation storage block behind the FIFO agent's `we`/`re`/`data_in`/`data_out`/`full`/`empty` pin set. The block adds configurable width and depth, programmable almost-full and almost-empty thresholds, an occupancy count, overflow/underflow error pulses and an optional first-word-fall-through (FWFT) read mode. It replaces fixed 32-bit FIFOs wherever the testbench drives through the driver/monitor clocking blocks.

## Interface
- `DATA_WIDTH`, default 32: width of `data_in`/`data_out`; ≥1.
- `DEPTH`, default 16: number of entries; power of two, ≥2.
- `AF_THRESH`, default DEPTH-2: `almost_full` asserts when count ≥ AF_THRESH; 1..DEPTH.
- `AE_THRESH`, default 2: `almost_empty` asserts when count ≤ AE_THRESH; 0..DEPTH-1.
- `FWFT`, default 0: 0 = registered read (1-cycle latency); 1 = head word presented on `data_out` while non-empty.
- `clk`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `we`  in  1  write request.
- `re`  in  1  read request.
- `data_in`  in  DATA_WIDTH  write data, sampled when a write is accepted.
- `data_out`  out  DATA_WIDTH  read data.
- `full`  out  1  count == DEPTH.
- `empty`  out  1  count == 0.
- `almost_full`  out  1  count ≥ AF_THRESH.
- `almost_empty`  out  1  count ≤ AE_THRESH.
- `count`  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- `overflow`  out  1  one-cycle pulse: a write was rejected.
- `underflow`  out  1  one-cycle pulse: a read was rejected.

## Operation
- Storage: DEPTH×DATA_WIDTH array. Write and read pointers are $clog2(DEPTH) bits and wrap naturally from DEPTH-1 to 0. The explicit `count` register is the single source for all flags.
- Write accepted = `we && (!full || re)`. An accepted write stores `data_in` at wr_ptr and increments wr_ptr.
- Read accepted = `re && !empty`. An accepted read increments rd_ptr.
- The `full || re` term applies to write acceptance only. A simultaneous we+re while full performs both operations, and count stays DEPTH.
- Simultaneous we+re while empty: the write is accepted, the read is rejected (underflow pulses), and count becomes 1.
- Count update: +1 on a write only, −1 on a read only, unchanged on both or neither.
- `overflow` is registered: 1 for the cycle after an edge where `we && full && !re`. That write is dropped and memory and pointers are unchanged.
- `underflow` is registered: 1 for the cycle after an edge where `re && empty`. Pointers are unchanged. When FWFT=0, `data_out` holds its previous value.
- FWFT=0: on an accepted read, `data_out` is loaded with mem[rd_ptr] at that edge and holds until the next accepted read.
- FWFT=1: `data_out` = mem[rd_ptr] whenever `empty`=0 and is don't-care while empty. An accepted read advances to the next entry.
- Reset (`reset`=1 at an edge) forces:
  - rd_ptr, wr_ptr and count to 0.
  - `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0.
  - `overflow`=0, `underflow`=0.
  - `data_out`=0 when FWFT=0.
- Memory contents are not cleared. Reset overrides `we`/`re` in the same cycle. A reset mid-stream discards all entries.

## Timing
- All outputs are registered or decoded from registers only. There is no combinational path from `we`/`re`/`data_in` to any output.
- Flags and `count` reflect the post-edge state in the cycle following the edge that changed them.
- FWFT=0 read latency: `re` sampled at edge N → data valid after edge N.
- FWFT=1 write-to-visible latency: a write at edge N into an empty FIFO → `empty`=0 and the word on `data_out` after edge N.
- Sustained throughput: one write and one read per cycle, including at full and at empty in FWFT mode with a standing word.
- Pointer wrap-around causes no bubble or flag glitch.

## Test plan
- Reset, then check idle outputs: `empty`=1, `full`=0, `almost_empty`=1, `almost_full`=0, `count`=0, `overflow`=`underflow`=0, `data_out`=0.
- Fill and drain, DEPTH=16, FWFT=0:
  - Write 0x00..0x0F; `full` asserts after the 16th write edge; `almost_full` asserts at count 14.
  - Read 16; `data_out` returns 0x00..0x0F in order, one cycle after each `re`.
  - `almost_empty` asserts at count 2; `empty`=1 at the end.
- Overflow/underflow:
  - With the FIFO full, a 17th `we` alone (0xDEAD) → `overflow` pulses 1 cycle, `count` stays 16, and 0xDEAD is never read out.
  - `re` while empty → `underflow` pulses and `data_out` is unchanged.
- Simultaneous we+re:
  - At full: count stays 16 and the new word is read last.
  - At empty: count goes to 1 and `underflow` pulses.
- Wrap-around: 40 interleaved write/read cycles with occupancy kept at 3–5 → in-order data and no flag glitches across pointer wrap.
- FWFT=1: write 0xA5 into an empty FIFO → `data_out`=0xA5 and `empty`=0 the next cycle with no `re`; assert `re` → `empty`=1 the following cycle.
- Reset at count 7 → next cycle `count`=0, `empty`=1, and subsequent reads return only newly written data.

Source files
------------

// File: rtl/sync_fifo_param.sv
// rtl/sync_fifo_param.sv - parametrised single-clock FIFO with thresholds, error pulses and optional FWFT read
module sync_fifo_param #(
    parameter int DATA_WIDTH = 32,
    parameter int DEPTH      = 16,
    parameter int AF_THRESH  = DEPTH - 2,
    parameter int AE_THRESH  = 2,
    parameter bit FWFT       = 1'b0
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       we,
    input  logic                       re,
    input  logic [DATA_WIDTH-1:0]      data_in,
    output logic [DATA_WIDTH-1:0]      data_out,
    output logic                       full,
    output logic                       empty,
    output logic                       almost_full,
    output logic                       almost_empty,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
    localparam logic [CW-1:0] AF_C    = CW'(AF_THRESH);
    localparam logic [CW-1:0] AE_C    = CW'(AE_THRESH);

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;
    logic                  wr_acc, rd_acc;

    // Every flag is decoded from the occupancy register alone.
    assign full         = (count_q == DEPTH_C);
    assign empty        = (count_q == '0);
    assign almost_full  = (count_q >= AF_C);
    assign almost_empty = (count_q <= AE_C);
    assign count        = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

    always_comb begin
        wr_acc      = we && (!full || re);
        rd_acc      = re && !empty;
        wr_ptr_d    = wr_acc ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d    = rd_acc ? rd_ptr_q + AW'(1) : rd_ptr_q;
        count_d     = count_q;
        case ({wr_acc, rd_acc})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
        overflow_d  = we && full && !re;
        underflow_d = re && empty;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
            overflow_q  <= overflow_d;
            underflow_q <= underflow_d;
        end
    end

    // Storage is deliberately left out of reset; stale words are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (!reset && wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

    generate
        if (FWFT) begin : g_fwft
            assign data_out = mem_q[rd_ptr_q];
        end else begin : g_reg
            logic [DATA_WIDTH-1:0] dout_q;

            always_ff @(posedge clk) begin
                if (reset) begin
                    dout_q <= '0;
                end else if (rd_acc) begin
                    dout_q <= mem_q[rd_ptr_q];
                end
            end

            assign data_out = dout_q;
        end
    endgenerate

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb/tb_sync_fifo_param.sv - scoreboard bench for sync_fifo_param, registered and FWFT instances in lockstep
module tb_sync_fifo_param;

    localparam int DW = 32;
    localparam int DEPTH = 16;

    logic          clk = 1'b0;
    logic          reset;
    logic          we;
    logic          re;
    logic [DW-1:0] data_in;

    logic [DW-1:0] dout0, dout1;
    logic          full0, empty0, af0, ae0, ovf0, udf0;
    logic          full1, empty1, af1, ae1, ovf1, udf1;
    logic [4:0]    cnt0, cnt1;

    always #5 clk = ~clk;

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b0)) u_reg (
        .clk(clk), .reset(reset), .we(we), .re(re), .data_in(data_in),
        .data_out(dout0), .full(full0), .empty(empty0), .almost_full(af0),
        .almost_empty(ae0), .count(cnt0), .overflow(ovf0), .underflow(udf0)
    );

    sync_fifo_param #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .FWFT(1'b1)) u_fwft (
        .clk(clk), .reset(reset), .we(we), .re(re), .data_in(data_in),
        .data_out(dout1), .full(full1), .empty(empty1), .almost_full(af1),
        .almost_empty(ae1), .count(cnt1), .overflow(ovf1), .underflow(udf1)
    );

    typedef struct {
        int            tag;
        logic [4:0]    cnt;
        logic          full, empty, af, ae, ovf, udf;
        logic [DW-1:0] d0;
        bit            d1_valid;
        logic [DW-1:0] d1;
    } exp_t;

    exp_t          sb[$];
    logic [DW-1:0] model_q[$];
    logic [DW-1:0] model_d0;
    int            edge_cnt = 0;
    int            vectors = 0;
    int            miscompares = 0;

    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    task automatic chk(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at edge %0d: got %0h, expected %0h", name, edge_cnt, act, exp);
        end
    endtask

    // Monitor: checks the expectation tagged for the edge that just happened.
    always @(negedge clk) begin
        if (sb.size() > 0 && sb[0].tag == edge_cnt) begin
            exp_t e;
            e = sb.pop_front();
            chk("count0", DW'(cnt0), DW'(e.cnt));
            chk("full0", DW'(full0), DW'(e.full));
            chk("empty0", DW'(empty0), DW'(e.empty));
            chk("almost_full0", DW'(af0), DW'(e.af));
            chk("almost_empty0", DW'(ae0), DW'(e.ae));
            chk("overflow0", DW'(ovf0), DW'(e.ovf));
            chk("underflow0", DW'(udf0), DW'(e.udf));
            chk("data_out0", dout0, e.d0);
            chk("count1", DW'(cnt1), DW'(e.cnt));
            chk("empty1", DW'(empty1), DW'(e.empty));
            chk("full1", DW'(full1), DW'(e.full));
            chk("overflow1", DW'(ovf1), DW'(e.ovf));
            chk("underflow1", DW'(udf1), DW'(e.udf));
            if (e.d1_valid) chk("data_out1", dout1, e.d1);
        end
    end

    // Drive one clock of stimulus and record what the reference queue says must follow.
    task automatic step(input bit rst, input bit w, input bit r, input logic [DW-1:0] d);
        exp_t e;
        int   sz;
        reset   = rst;
        we      = w;
        re      = r;
        data_in = d;
        sz      = model_q.size();
        e.ovf   = 1'b0;
        e.udf   = 1'b0;
        if (rst) begin
            model_q.delete();
            model_d0 = '0;
        end else begin
            e.ovf = w && (sz == DEPTH) && !r;
            e.udf = r && (sz == 0);
            if (r && sz > 0) model_d0 = model_q.pop_front();
            if (w && (sz < DEPTH || r)) model_q.push_back(d);
        end
        sz         = model_q.size();
        e.tag      = edge_cnt + 1;
        e.cnt      = 5'(sz);
        e.full     = (sz == DEPTH);
        e.empty    = (sz == 0);
        e.af       = (sz >= DEPTH - 2);
        e.ae       = (sz <= 2);
        e.d0       = model_d0;
        e.d1_valid = (sz > 0);
        e.d1       = (sz > 0) ? model_q[0] : '0;
        sb.push_back(e);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        model_d0 = '0;
        step(1, 0, 0, '0);
        step(1, 0, 0, '0);
        step(0, 0, 0, '0);

        // Fill 0x00..0x0F, then a rejected write and a both-ways op at full.
        for (int i = 0; i < DEPTH; i++) step(0, 1, 0, DW'(i));
        step(0, 1, 0, 32'hDEAD);
        step(0, 0, 0, '0);
        step(0, 1, 1, 32'h100);
        for (int i = 0; i < DEPTH; i++) step(0, 0, 1, '0);

        // Empty corners: lone read, then simultaneous write+read.
        step(0, 0, 1, '0);
        step(0, 0, 0, '0);
        step(0, 1, 1, 32'hBEEF);
        step(0, 0, 1, '0);

        // Interleaved traffic holding occupancy in 3..5 across several pointer wraps.
        for (int i = 0; i < 4; i++) step(0, 1, 0, $urandom);
        for (int i = 0; i < 40; i++) begin
            int  sz;
            bit  w, r;
            sz = model_q.size();
            w  = (sz <= 3) ? 1'b1 : 1'($urandom_range(0, 1));
            r  = (sz >= 5) ? 1'b1 : 1'($urandom_range(0, 1));
            step(0, w, r, $urandom);
        end
        while (model_q.size() > 0) step(0, 0, 1, '0);

        // FWFT visibility without a read, then drain.
        step(1, 0, 0, '0);
        step(0, 1, 0, 32'hA5);
        step(0, 0, 0, '0);
        step(0, 0, 1, '0);
        step(0, 0, 0, '0);

        // Reset at occupancy 7 discards everything.
        for (int i = 0; i < 7; i++) step(0, 1, 0, 32'h7000 + DW'(i));
        step(1, 1, 1, 32'hBAD);
        step(0, 1, 0, 32'h51);
        step(0, 1, 0, 32'h52);
        step(0, 0, 1, '0);
        step(0, 0, 1, '0);
        step(0, 0, 1, '0);

        // Free-running random traffic with rare resets.
        for (int i = 0; i < 400; i++) begin
            step(($urandom_range(0, 99) == 0), 1'($urandom_range(0, 1)),
                 1'($urandom_range(0, 1)), $urandom);
        end
        step(0, 0, 0, '0);

        @(negedge clk);
        @(negedge clk);
        vectors++;
        if (sb.size() != 0) begin
            miscompares++;
            $display("FAIL scoreboard_drain: %0d expectations left, expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
